// File: rtl/apb_master_nslave.sv
// APB3 master bridge: turns a single-outstanding valid/ready request into
// SETUP/ENABLE transfers to one of NUM_SLV slaves, with decode errors and wait-state timeout.
module apb_master_nslave #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_DECERR = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [SEL_W-1:0]    req_idx_s;
    logic                dec_err_s;
    logic [NUM_SLV-1:0]  idx_onehot_s;
    logic                pready_sel_s;
    logic                pslverr_sel_s;
    logic [DATA_W-1:0]   prdata_sel_s;
    logic                timeout_s;
    logic                done_s;
    logic                accept_s;

    // The slave index comes from the top address bits; a single slave always decodes to 0.
    generate
        if (NUM_SLV == 1) begin : g_one_slave
            assign req_idx_s = '0;
            assign dec_err_s = 1'b0;
        end else begin : g_multi_slave
            assign req_idx_s = req_addr[ADDR_W-1 -: SEL_W];
            assign dec_err_s = (32'(req_idx_s) >= NUM_SLV);
        end
    endgenerate

    // Mux the latched slave's response lines and build the one-hot select for a new request.
    always_comb begin
        pready_sel_s  = 1'b0;
        pslverr_sel_s = 1'b0;
        prdata_sel_s  = '0;
        idx_onehot_s  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            pready_sel_s    = pready_sel_s  | (PREADY[i]  & (SEL_W'(i) == sel_q));
            pslverr_sel_s   = pslverr_sel_s | (PSLVERR[i] & (SEL_W'(i) == sel_q));
            prdata_sel_s    = prdata_sel_s  |
                              (PRDATA[i*DATA_W +: DATA_W] & {DATA_W{SEL_W'(i) == sel_q}});
            idx_onehot_s[i] = (SEL_W'(i) == req_idx_s);
        end
    end

    // req_ready must follow PREADY within the completing cycle to allow back-to-back transfers,
    // so it is the one output decoded combinationally from registered state.
    assign timeout_s = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign done_s    = (state_q == ST_ENABLE) && (pready_sel_s || timeout_s);
    assign req_ready = (state_q == ST_IDLE) || done_s;
    assign accept_s  = req_valid && req_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (done_s) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    if (pready_sel_s) begin
                        rsp_err_d   = pslverr_sel_s;
                        rsp_rdata_d = (!pwrite_q && !pslverr_sel_s) ? prdata_sel_s : '0;
                    end else begin
                        rsp_err_d   = 1'b1;
                    end
                end else begin
                    penable_d = 1'b1;
                end
            end
            ST_DECERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase

        // A new request (from IDLE or on the completing ENABLE edge) overrides the return to IDLE.
        if (accept_s) begin
            paddr_d   = req_addr;
            pwrite_d  = req_write;
            pwdata_d  = req_wdata;
            penable_d = 1'b0;
            cnt_d     = '0;
            if (dec_err_s) begin
                state_d = ST_DECERR;
                psel_d  = '0;
            end else begin
                state_d = ST_SETUP;
                psel_d  = idx_onehot_s;
                sel_d   = req_idx_s;
            end
        end else begin
            cnt_d = ((state_q == ST_ENABLE) && !done_s) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Randomized bench for apb_master_nslave: a transaction-level model predicts each response
// and its arrival cycle while an APB slave responder plays out the chosen wait/error behaviour.
module tb_apb_master_nslave;

    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [8:0] addr;
        logic       wr;
        logic [7:0] wdata;
        int         wt;
        logic       serr;
        logic [7:0] data;
    } xfer_t;

    typedef struct packed {
        int         cyc;
        logic       err;
        logic [7:0] rdata;
    } rsp_t;

    logic        PCLK, PRESETn;
    logic        req_valid, req_ready, req_write;
    logic [8:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [1:0]  PSEL, PREADY, PSLVERR;
    logic        PENABLE, PWRITE;
    logic [8:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [15:0] PRDATA;

    logic        req_valid3, req_ready3, rsp_valid3, rsp_err3, PENABLE3, PWRITE3;
    logic [7:0]  rsp_rdata3, PWDATA3;
    logic [2:0]  PSEL3, PREADY3, PSLVERR3;
    logic [8:0]  PADDR3;
    logic [23:0] PRDATA3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rsp    = 0;
    int en_seen  = 0;
    logic  have_cur = 1'b0;
    logic [8:0] last_addr = 9'h000;
    xfer_t cur;
    xfer_t slave_q[$];
    rsp_t  rsp_q[$];

    apb_master_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(TIMEOUT)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(TIMEOUT)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .PSEL(PSEL3), .PENABLE(PENABLE3), .PADDR(PADDR3), .PWRITE(PWRITE3), .PWDATA(PWDATA3),
        .PRDATA(PRDATA3), .PREADY(PREADY3), .PSLVERR(PSLVERR3)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response predicted from the transfer's slave behaviour: latency in cycles after accept.
    function automatic rsp_t model(input xfer_t t, input int acc);
        rsp_t r;
        if (t.wt < TIMEOUT) begin
            r.cyc   = acc + 1 + (t.wt + 1);
            r.err   = t.serr;
            r.rdata = (!t.wr && !t.serr) ? t.data : 8'h00;
        end else begin
            r.cyc   = acc + 1 + TIMEOUT;
            r.err   = 1'b1;
            r.rdata = 8'h00;
        end
        return r;
    endfunction

    // Slave responder and bus/response monitor for the two-slave instance.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            rsp_q.delete();
            slave_q.delete();
            have_cur  = 1'b0;
            last_addr = 9'h000;
        end else begin
            check_eq("psel_onehot", 32'($countones(PSEL) <= 1), 32'd1);
            if (PENABLE) check_eq("penable_psel", 32'(PSEL != 2'b00), 32'd1);
            if (PSEL != 2'b00 && !PENABLE) begin
                if (slave_q.size() > 0) begin
                    cur       = slave_q.pop_front();
                    have_cur  = 1'b1;
                    en_seen   = 0;
                    last_addr = cur.addr;
                end else begin
                    check_eq("setup_unexpected", 32'(slave_q.size()), 32'd1);
                    have_cur = 1'b0;
                end
            end
            if (PSEL != 2'b00 && have_cur) begin
                check_eq("psel",   32'(PSEL),   32'(2'b01 << cur.addr[8]));
                check_eq("paddr",  32'(PADDR),  32'(cur.addr));
                check_eq("pwrite", 32'(PWRITE), 32'(cur.wr));
                check_eq("pwdata", 32'(PWDATA), 32'(cur.wdata));
            end else if (PSEL == 2'b00) begin
                check_eq("paddr_hold", 32'(PADDR), 32'(last_addr));
            end
            if (rsp_valid) begin
                n_rsp++;
                if (rsp_q.size() > 0) begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check_eq("rsp_cycle", 32'(cyc),       32'(e.cyc));
                    check_eq("rsp_err",   32'(rsp_err),   32'(e.err));
                    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                end else begin
                    check_eq("rsp_unexpected", 32'(rsp_q.size()), 32'd1);
                end
            end
            PRDATA  = 16'($urandom);
            PREADY  = 2'($urandom);
            PSLVERR = 2'($urandom);
            if (PSEL != 2'b00 && PENABLE && have_cur) begin
                PREADY[cur.addr[8]]           = (en_seen >= cur.wt);
                PSLVERR[cur.addr[8]]          = cur.serr;
                PRDATA[cur.addr[8]*8 +: 8]    = cur.data;
                en_seen++;
            end
        end
    end

    task automatic do_xfer(input xfer_t t, output int acc);
        @(negedge PCLK);
        req_valid = 1'b1;
        req_addr  = t.addr;
        req_write = t.wr;
        req_wdata = t.wdata;
        acc = -1;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            #4;
            if (req_ready) begin
                acc = cyc + 1;
                slave_q.push_back(t);
                rsp_q.push_back(model(t, acc));
                @(posedge PCLK);
            end else begin
                @(negedge PCLK);
            end
        end
        if (acc < 0) check_eq("accept_timeout", 32'(acc), 32'd0);
    endtask

    task automatic idle(input int n);
        @(negedge PCLK);
        req_valid = 1'b0;
        req_addr  = 9'($urandom);
        req_wdata = 8'($urandom);
        req_write = 1'($urandom);
        repeat (n - 1) @(negedge PCLK);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && rsp_q.size() > 0; k++) @(negedge PCLK);
        check_eq("drain", 32'(rsp_q.size()), 32'd0);
    endtask

    // One request to the three-slave instance, observed for a few cycles afterwards.
    task automatic run3(input logic [8:0] addr, input logic wr, input logic exp_err,
                        input logic [7:0] exp_rdata, input int exp_lat, input logic [2:0] exp_psel);
        int acc, rcyc, nr;
        logic [2:0] seen;
        logic       rerr;
        logic [7:0] rdat;
        seen = 3'b000; nr = 0; rcyc = -1; rerr = 1'b0; rdat = 8'h00;
        @(negedge PCLK);
        req_valid3 = 1'b1;
        req_addr   = addr;
        req_write  = wr;
        req_wdata  = 8'h5A;
        #4;
        check_eq("d3_ready", 32'(req_ready3), 32'd1);
        acc = cyc + 1;
        @(negedge PCLK);
        req_valid3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_eq("d3_psel_onehot", 32'($countones(PSEL3) <= 1), 32'd1);
            seen = seen | PSEL3;
            if (rsp_valid3) begin
                nr++;
                rcyc = cyc;
                rerr = rsp_err3;
                rdat = rsp_rdata3;
            end
            @(negedge PCLK);
        end
        check_eq("d3_psel",   32'(seen),       32'(exp_psel));
        check_eq("d3_nrsp",   32'(nr),         32'd1);
        check_eq("d3_lat",    32'(rcyc - acc), 32'(exp_lat));
        check_eq("d3_err",    32'(rerr),       32'(exp_err));
        check_eq("d3_rdata",  32'(rdat),       32'(exp_rdata));
    endtask

    initial begin
        int acc1, acc2, rsp_before, sel;
        xfer_t t;
        PRESETn = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0;
        req_write = 1'b0; req_addr = 9'h000; req_wdata = 8'h00;
        PREADY = 2'b00; PSLVERR = 2'b00; PRDATA = 16'h0000;
        PREADY3 = 3'b111; PSLVERR3 = 3'b000; PRDATA3 = 24'h332211;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        #1;
        check_eq("rst_psel",    32'(PSEL),      32'd0);
        check_eq("rst_penable", 32'(PENABLE),   32'd0);
        check_eq("rst_paddr",   32'(PADDR),     32'd0);
        check_eq("rst_pwdata",  32'(PWDATA),    32'd0);
        check_eq("rst_rsp",     32'(rsp_valid), 32'd0);
        check_eq("rst_ready",   32'(req_ready), 32'd1);

        // Directed: zero-wait write, 3-wait read from slave 1, slave error on read, timeout.
        t = '{addr: 9'h005, wr: 1'b1, wdata: 8'hA5, wt: 0, serr: 1'b0, data: 8'h00};
        do_xfer(t, acc1); idle(3);
        t = '{addr: 9'h1F0, wr: 1'b0, wdata: 8'h11, wt: 3, serr: 1'b0, data: 8'h3C};
        do_xfer(t, acc1); idle(1);
        t = '{addr: 9'h012, wr: 1'b0, wdata: 8'h22, wt: 0, serr: 1'b1, data: 8'h77};
        do_xfer(t, acc1); idle(1);
        t = '{addr: 9'h140, wr: 1'b1, wdata: 8'h33, wt: TIMEOUT + 5, serr: 1'b0, data: 8'h00};
        do_xfer(t, acc1); idle(2);
        drain();

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 7);
            t.addr  = 9'($urandom);
            t.wr    = 1'($urandom);
            t.wdata = 8'($urandom);
            t.data  = 8'($urandom);
            t.serr  = ($urandom_range(0, 3) == 0);
            t.wt    = (sel < 5) ? $urandom_range(0, 3) :
                      (sel == 5) ? TIMEOUT - 1 : (sel == 6) ? TIMEOUT : TIMEOUT + 3;
            do_xfer(t, acc1);
            sel = $urandom_range(0, 2);
            if (sel > 0) idle(sel);
        end
        idle(1);
        drain();

        // Back-to-back writes, then reset in the middle of the second ENABLE phase.
        t = '{addr: 9'h00C, wr: 1'b1, wdata: 8'hC3, wt: 0, serr: 1'b0, data: 8'h00};
        do_xfer(t, acc1);
        t = '{addr: 9'h1AB, wr: 1'b1, wdata: 8'h96, wt: 10, serr: 1'b0, data: 8'h00};
        do_xfer(t, acc2);
        check_eq("b2b_gap", 32'(acc2 - acc1), 32'd2);
        @(negedge PCLK);
        req_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        check_eq("mid_enable", 32'(PENABLE), 32'd1);
        rsp_before = n_rsp;
        #2;
        PRESETn = 1'b0;
        #1;
        check_eq("arst_psel",    32'(PSEL),      32'd0);
        check_eq("arst_penable", 32'(PENABLE),   32'd0);
        check_eq("arst_paddr",   32'(PADDR),     32'd0);
        check_eq("arst_pwrite",  32'(PWRITE),    32'd0);
        check_eq("arst_pwdata",  32'(PWDATA),    32'd0);
        check_eq("arst_rsp",     32'(rsp_valid), 32'd0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (20) @(negedge PCLK);
        check_eq("no_rsp_after_rst", 32'(n_rsp - rsp_before), 32'd0);

        // Three-slave instance: decode error, then valid accesses to slaves 2 and 1.
        run3(9'h1C0, 1'b0, 1'b1, 8'h00, 1, 3'b000);
        run3(9'h100, 1'b0, 1'b0, 8'h33, 2, 3'b100);
        run3(9'h080, 1'b1, 1'b0, 8'h00, 2, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
